// File: rtl/see_cone_monitor.sv
// rtl/see_cone_monitor.sv - golden/faulty cone output comparator with campaign counters
module see_cone_monitor #(
    parameter int CNT_W = 16,
    parameter int VEC_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             smp_valid,
    input  logic [VEC_W-1:0] vec_in,
    input  logic             golden_out,
    input  logic             faulty_out,
    output logic             busy,
    output logic             done,
    output logic             err_pulse,
    output logic             err_seen,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [VEC_W-1:0] first_err_vec,
    output logic [CNT_W-1:0] first_err_idx
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] vec_nxt;
    logic             accept;
    logic             mismatch;
    logic             last;
    logic             arm;

    // The mismatch term is only consumed under accept, so X on the cone
    // outputs during invalid cycles never reaches state.
    assign accept   = (state == S_RUN) && smp_valid;
    assign mismatch = golden_out ^ faulty_out;
    assign vec_nxt  = vec_cnt + CNT_W'(1);
    assign last     = (vec_nxt == target);
    assign arm      = (state != S_RUN) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (accept && last) state_nxt = S_DONE;
            S_DONE:  if (start) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target        <= '0;
            vec_cnt       <= '0;
            err_cnt       <= '0;
            err_seen      <= 1'b0;
            err_pulse     <= 1'b0;
            first_err_vec <= '0;
            first_err_idx <= '0;
        end else if (arm) begin
            target        <= (num_vec == '0) ? CNT_W'(1) : num_vec;
            vec_cnt       <= '0;
            err_cnt       <= '0;
            err_seen      <= 1'b0;
            err_pulse     <= 1'b0;
            first_err_vec <= '0;
            first_err_idx <= '0;
        end else begin
            err_pulse <= accept && mismatch;
            if (accept) begin
                vec_cnt <= vec_nxt;
                if (mismatch) begin
                    if (err_cnt != '1) begin
                        err_cnt <= err_cnt + CNT_W'(1);
                    end
                    if (!err_seen) begin
                        first_err_vec <= vec_in;
                        first_err_idx <= vec_cnt;
                        err_seen      <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_see_cone_monitor.sv
// tb/tb_see_cone_monitor.sv - directed self-checking bench for see_cone_monitor
module tb_see_cone_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start4 = 1'b0;
    logic [15:0] num_vec = '0;
    logic [3:0]  num_vec4 = '0;
    logic        smp_valid = 1'b0;
    logic [8:0]  vec_in = '0;
    logic        golden_out = 1'b0;
    logic        faulty_out = 1'b0;

    logic        busy, done, err_pulse, err_seen;
    logic [15:0] vec_cnt, err_cnt, first_err_idx;
    logic [8:0]  first_err_vec;

    logic        busy4, done4, err_pulse4, err_seen4;
    logic [3:0]  vec_cnt4, err_cnt4, first_err_idx4;
    logic [8:0]  first_err_vec4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    see_cone_monitor #(.CNT_W(16), .VEC_W(9)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
        .smp_valid(smp_valid), .vec_in(vec_in),
        .golden_out(golden_out), .faulty_out(faulty_out),
        .busy(busy), .done(done), .err_pulse(err_pulse), .err_seen(err_seen),
        .vec_cnt(vec_cnt), .err_cnt(err_cnt),
        .first_err_vec(first_err_vec), .first_err_idx(first_err_idx)
    );

    see_cone_monitor #(.CNT_W(4), .VEC_W(9)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .num_vec(num_vec4),
        .smp_valid(smp_valid), .vec_in(vec_in),
        .golden_out(golden_out), .faulty_out(faulty_out),
        .busy(busy4), .done(done4), .err_pulse(err_pulse4), .err_seen(err_seen4),
        .vec_cnt(vec_cnt4), .err_cnt(err_cnt4),
        .first_err_vec(first_err_vec4), .first_err_idx(first_err_idx4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [8:0] v, input logic g, input logic f);
        smp_valid  = 1'b1;
        vec_in     = v;
        golden_out = g;
        faulty_out = f;
        step();
    endtask

    task automatic idle_cycle();
        smp_valid  = 1'b0;
        golden_out = 1'bx;
        faulty_out = 1'bx;
        step();
    endtask

    task automatic arm(input logic [15:0] n);
        start     = 1'b1;
        num_vec   = n;
        smp_valid = 1'b0;
        step();
        start = 1'b0;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pulse", err_pulse, 0);
        check("rst_seen", err_seen, 0);
        check("rst_vcnt", vec_cnt, 0);
        check("rst_ecnt", err_cnt, 0);
        check("rst_fvec", first_err_vec, 0);
        check("rst_fidx", first_err_idx, 0);

        // 4 matching samples
        arm(16'd4);
        check("t1_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            sample(9'(i + 1), 1'b1, 1'b1);
            if (i == 2) check("t1_not_done", done, 0);
        end
        smp_valid = 1'b0;
        check("t1_done", done, 1);
        check("t1_busy_lo", busy, 0);
        check("t1_vcnt", vec_cnt, 4);
        check("t1_ecnt", err_cnt, 0);
        check("t1_seen", err_seen, 0);

        // 5 samples, mismatches at 2 and 4; start arrives while in DONE
        arm(16'd5);
        check("t2_done_clr", done, 0);
        check("t2_vcnt_clr", vec_cnt, 0);
        sample(9'h011, 1'b0, 1'b0);
        sample(9'h022, 1'b1, 1'b1);
        sample(9'h0A5, 1'b1, 1'b0);
        check("t2_pulse_a", err_pulse, 1);
        check("t2_fidx_a", first_err_idx, 2);
        sample(9'h033, 1'b0, 1'b0);
        check("t2_pulse_gap", err_pulse, 0);
        sample(9'h1FF, 1'b0, 1'b1);
        check("t2_pulse_b", err_pulse, 1);
        check("t2_done", done, 1);
        check("t2_ecnt", err_cnt, 2);
        check("t2_fidx", first_err_idx, 2);
        check("t2_fvec", first_err_vec, 9'h0A5);
        check("t2_seen", err_seen, 1);
        idle_cycle();
        check("t2_pulse_end", err_pulse, 0);
        check("t2_done_hold", done, 1);

        // valid pattern 1,0,0,1,0,1 with X on outputs when invalid
        arm(16'd3);
        sample(9'h001, 1'b1, 1'b1);
        idle_cycle();
        idle_cycle();
        sample(9'h002, 1'b0, 1'b0);
        idle_cycle();
        check("t3_not_done", done, 0);
        check("t3_vcnt_mid", vec_cnt, 2);
        sample(9'h003, 1'b1, 1'b1);
        check("t3_done", done, 1);
        check("t3_vcnt", vec_cnt, 3);
        check("t3_ecnt", err_cnt, 0);
        sample(9'h004, 1'b1, 1'b0);
        smp_valid = 1'b0;
        check("t3_ignore_vcnt", vec_cnt, 3);
        check("t3_ignore_ecnt", err_cnt, 0);

        // CNT_W=4, 15 mismatching samples
        start4   = 1'b1;
        num_vec4 = 4'd15;
        step();
        start4 = 1'b0;
        for (int i = 0; i < 15; i++) sample(9'(i + 9'h040), 1'b1, 1'b0);
        smp_valid = 1'b0;
        check("t4_ecnt", err_cnt4, 15);
        check("t4_vcnt", vec_cnt4, 15);
        check("t4_done", done4, 1);
        check("t4_fidx", first_err_idx4, 0);
        check("t4_fvec", first_err_vec4, 9'h040);

        // abort mid-campaign; start in RUN ignored; rst beats start
        arm(16'd6);
        sample(9'h0C3, 1'b1, 1'b0);
        start   = 1'b1;
        num_vec = 16'd1;
        sample(9'h0C4, 1'b1, 1'b1);
        start = 1'b0;
        check("t5_run_start_ign", vec_cnt, 2);
        check("t5_busy", busy, 1);
        smp_valid = 1'b0;
        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_vcnt", vec_cnt, 0);
        check("t5_rst_ecnt", err_cnt, 0);
        check("t5_rst_seen", err_seen, 0);
        check("t5_rst_fvec", first_err_vec, 0);
        arm(16'd1);
        sample(9'h055, 1'b0, 1'b0);
        smp_valid = 1'b0;
        check("t5_done", done, 1);
        check("t5_vcnt", vec_cnt, 1);
        check("t5_ecnt", err_cnt, 0);
        check("t5_seen", err_seen, 0);

        // num_vec = 0 behaves as 1, then re-arm from DONE
        arm(16'd0);
        sample(9'h077, 1'b1, 1'b0);
        smp_valid = 1'b0;
        check("t6_done", done, 1);
        check("t6_vcnt", vec_cnt, 1);
        check("t6_ecnt", err_cnt, 1);
        arm(16'd2);
        check("t6_rearm_done", done, 0);
        check("t6_rearm_busy", busy, 1);
        check("t6_rearm_vcnt", vec_cnt, 0);
        check("t6_rearm_ecnt", err_cnt, 0);
        check("t6_rearm_seen", err_seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
